pipelined_timer: RTL and testbench

PIPELINED_TIMER -- requirements
Module: pipelined_timer

---
 rtl/pipelined_timer.sv | 208 ++++++++++++++++++++
 tb/tb_pipelined_timer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_timer.sv
// Purpose : tick-counting timer; counts accepted enable ticks up to a latched
//           period and emits a strobe, either once (one-shot) or repeatedly
//           (periodic). The count is kept in chunks with a registered carry
//           between chunks, so no full-width adder sits in one cycle.
// Latency : a tick accepted in cycle t keeps the block in SETTLE for cycles
//           t+1..t+LATENCY; the strobe, if any, is high in cycle t+LATENCY+1.
// Backpressure: tick_ready is high only in RUN. An enable that arrives while
//           tick_ready is low and the block is busy is dropped and sets the
//           sticky overrun flag. An enable in IDLE is dropped silently.
// Ports   : clk, rst (async, active-high); start/stop/mode/period control;
//           enable/tick_ready tick handshake; strobe, busy, done, overrun, err
//           status. Optional output event_count[15:0] exists only when the
//           macro PIPELINED_TIMER_EVENT_COUNT_EN is defined.
module pipelined_timer #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic             enable,
  output logic             tick_ready,
  output logic             strobe,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic             err
`ifdef PIPELINED_TIMER_EVENT_COUNT_EN
  ,
  output logic [15:0]      event_count
`endif
);

  // Chunk width, chunk count and the padded width holding all chunks.
  localparam int CW  = (WIDTH + LATENCY - 1) / LATENCY;
  localparam int NCH = (WIDTH + CW - 1) / CW;
  localparam int PW  = NCH * CW;
  localparam int SCW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;

  state_t         state;
  logic [PW-1:0]  cnt;        // tick count, zero-padded to whole chunks
  logic [PW-1:0]  per;        // latched period, same padding
  logic           mode_q;
  logic [NCH-1:0] carry;      // carry[k]: registered carry into chunk k
  logic [NCH-1:0] cmp;        // cmp[k]: chunk k of the new count equals period
  logic [SCW-1:0] sc;         // settle cycle index, 1..LATENCY

  logic [PW-1:0]  sum_now;
  logic [NCH-1:0] eq_now;
  logic [NCH-1:0] carry_nxt;
  logic [NCH-1:0] proc;       // proc[k]: chunk k is updated on this edge
  logic [CW:0]    tmp;
  logic           cin;
  logic           cout_prev;
  logic           start_ok;
  logic           strobe_set;

  // A start with period 0 is rejected; stop always beats start.
  assign start_ok = start && !stop && (period != '0);

  // Chunk 0 is updated on the accepting edge, chunk k on the k-th settle edge,
  // so the carry out of chunk k-1 is already registered when chunk k adds it.
  always_comb begin
    proc    = '0;
    proc[0] = (state == RUN) && enable;
    for (int k = 1; k < NCH; k++) begin
      proc[k] = (state == SETTLE) && (sc == SCW'(k));
    end
  end

  // Per-chunk incrementer and equality compare against the latched period.
  // The top chunk's carry-out can only appear if the count passed the period,
  // so it forces a mismatch there.
  always_comb begin
    sum_now   = '0;
    eq_now    = '0;
    carry_nxt = '0;
    tmp       = '0;
    cin       = 1'b0;
    cout_prev = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      cin = (k == 0) ? 1'b1 : carry[k];
      tmp = {1'b0, cnt[k*CW +: CW]} + (CW+1)'(cin);
      sum_now[k*CW +: CW] = tmp[CW-1:0];
      eq_now[k] = (tmp[CW-1:0] == per[k*CW +: CW]) && !((k == NCH-1) && tmp[CW]);
      if (k > 0) begin
        carry_nxt[k] = cout_prev;
      end
      cout_prev = tmp[CW];
    end
  end

  // Last settle cycle: every chunk compare is registered, AND them together.
  assign strobe_set = !stop && !start_ok && (state == SETTLE) &&
                      (sc == SCW'(LATENCY)) && (&cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      per        <= '0;
      mode_q     <= 1'b0;
      carry      <= '0;
      cmp        <= '0;
      sc         <= '0;
      strobe     <= 1'b0;
      busy       <= 1'b0;
      tick_ready <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      err        <= 1'b0;
    end else begin
      strobe <= 1'b0;
      err    <= 1'b0;
      // Only SETTLE is busy with tick_ready low; an accepted start clears it below.
      if (enable && (state == SETTLE)) begin
        overrun <= 1'b1;
      end
      if (stop) begin
        state      <= IDLE;
        busy       <= 1'b0;
        tick_ready <= 1'b0;
        carry      <= '0;
        cmp        <= '0;
        sc         <= '0;
      end else if (start_ok) begin
        per        <= PW'(period);
        mode_q     <= mode;
        cnt        <= '0;
        carry      <= '0;
        cmp        <= '0;
        sc         <= '0;
        done       <= 1'b0;
        overrun    <= 1'b0;
        state      <= RUN;
        busy       <= 1'b1;
        tick_ready <= 1'b1;
      end else begin
        if (start) begin
          err <= 1'b1;
        end
        for (int k = 0; k < NCH; k++) begin
          if (proc[k]) begin
            cnt[k*CW +: CW] <= sum_now[k*CW +: CW];
            cmp[k]          <= eq_now[k];
          end
        end
        for (int k = 1; k < NCH; k++) begin
          if (proc[k-1]) begin
            carry[k] <= carry_nxt[k];
          end
        end
        case (state)
          RUN: begin
            if (enable) begin
              state      <= SETTLE;
              tick_ready <= 1'b0;
              sc         <= SCW'(1);
            end
          end
          SETTLE: begin
            if (sc == SCW'(LATENCY)) begin
              if (strobe_set) begin
                strobe <= 1'b1;
                if (mode_q) begin
                  cnt        <= '0;
                  state      <= RUN;
                  tick_ready <= 1'b1;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
                state      <= RUN;
                tick_ready <= 1'b1;
              end
            end else begin
              sc <= sc + SCW'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef PIPELINED_TIMER_EVENT_COUNT_EN
  // Strobe counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_count <= '0;
    end else if (start_ok) begin
      event_count <= '0;
    end else if (strobe_set) begin
      event_count <= event_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_timer.sv
// Directed bench for pipelined_timer: an 8-bit/LATENCY=2 instance carries the
// control tests, a 32-bit/LATENCY=5 instance counts across chunk boundaries.
`timescale 1ns/1ps
module tb_pipelined_timer;
  localparam int L  = 2;
  localparam int L2 = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, mode, enable;
  logic [7:0]  period;
  logic        tick_ready, strobe, busy, done, overrun, err;

  logic        start2, stop2, mode2, enable2;
  logic [31:0] period2;
  logic        tick_ready2, strobe2, busy2, done2, overrun2, err2;

`ifdef PIPELINED_TIMER_EVENT_COUNT_EN
  logic [15:0] event_count, event_count2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int early2   = 0;
  int seen     = 0;

  always #5 clk = ~clk;

  pipelined_timer #(.WIDTH(8), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .period(period), .enable(enable), .tick_ready(tick_ready),
    .strobe(strobe), .busy(busy), .done(done), .overrun(overrun), .err(err)
`ifdef PIPELINED_TIMER_EVENT_COUNT_EN
    , .event_count(event_count)
`endif
  );

  pipelined_timer #(.WIDTH(32), .LATENCY(L2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .mode(mode2),
    .period(period2), .enable(enable2), .tick_ready(tick_ready2),
    .strobe(strobe2), .busy(busy2), .done(done2), .overrun(overrun2), .err(err2)
`ifdef PIPELINED_TIMER_EVENT_COUNT_EN
    , .event_count(event_count2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted tick; returns in cycle t+L+1 where the strobe would show.
  task automatic tick();
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (L) step();
  endtask

  task automatic tick2();
    enable2 = 1'b1;
    step();
    enable2 = 1'b0;
    repeat (L2 - 1) begin
      step();
      if (strobe2) early2++;
    end
    step();
  endtask

  task automatic go(input logic [7:0] p, input logic m);
    start  = 1'b1;
    period = p;
    mode   = m;
    step();
    start  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; enable = 1'b0; period = '0;
    start2 = 1'b0; stop2 = 1'b0; mode2 = 1'b0; enable2 = 1'b0; period2 = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_tick_ready", tick_ready, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_err", err, 0);
`ifdef PIPELINED_TIMER_EVENT_COUNT_EN
    chk("rst_event_count", event_count, 0);
`endif
    rst = 1'b0;
    step();

    // Periodic, period 3: strobe on every third tick, busy throughout.
    go(8'd3, 1'b1);
    chk("p3_busy", busy, 1);
    chk("p3_ready", tick_ready, 1);
    tick(); chk("p3_t1", strobe, 0);
    tick(); chk("p3_t2", strobe, 0);
    tick(); chk("p3_t3", strobe, 1);
    chk("p3_busy_at_strobe", busy, 1);
    chk("p3_ready_at_strobe", tick_ready, 1);
    step(); chk("p3_pulse_one_cycle", strobe, 0);
    tick(); chk("p3_t4", strobe, 0);
    tick(); chk("p3_t5", strobe, 0);
    tick(); chk("p3_t6", strobe, 1);
`ifdef PIPELINED_TIMER_EVENT_COUNT_EN
    chk("p3_event_count", event_count, 2);
`endif

    // One-shot, period 2.
    go(8'd2, 1'b0);
    tick(); chk("os_t1", strobe, 0);
    tick(); chk("os_t2", strobe, 1);
    chk("os_done", done, 1);
    chk("os_busy", busy, 0);
    chk("os_ready", tick_ready, 0);
    enable = 1'b1;
    step();
    step();
    enable = 1'b0;
    chk("os_idle_enable_no_overrun", overrun, 0);

    // Enable held through SETTLE: overrun set, count moves by one only.
    go(8'd3, 1'b1);
    chk("ov_done_cleared", done, 0);
    enable = 1'b1;
    step();
    step();
    chk("ov_set", overrun, 1);
    enable = 1'b0;
    step();
    chk("ov_no_strobe", strobe, 0);
    chk("ov_back_in_run", tick_ready, 1);
    tick(); chk("ov_t2", strobe, 0);
    tick(); chk("ov_t3", strobe, 1);
    go(8'd2, 1'b1);
    chk("ov_cleared_by_start", overrun, 0);

    // Rejected start and start+stop collision.
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_idle", busy, 0);
    go(8'd0, 1'b1);
    chk("zero_err", err, 1);
    chk("zero_busy", busy, 0);
    step();
    chk("zero_err_one_cycle", err, 0);
    go(8'd4, 1'b1);
    chk("restart_busy", busy, 1);
    start = 1'b1; stop = 1'b1; period = 8'd5;
    step();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_err", err, 0);
    chk("startstop_ready", tick_ready, 0);

    // Stop in SETTLE suppresses the pending strobe and leaves done alone.
    go(8'd1, 1'b0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_settle_busy", busy, 0);
    step();
    chk("stop_settle_no_strobe", strobe, 0);
    chk("stop_settle_done", done, 0);

    // Start while busy discards the in-flight tick.
    go(8'd1, 1'b1);
    enable = 1'b1;
    step();
    enable = 1'b0;
    go(8'd2, 1'b1);
    chk("rs_ready", tick_ready, 1);
    step(); chk("rs_no_strobe_a", strobe, 0);
    step(); chk("rs_no_strobe_b", strobe, 0);
    tick(); chk("rs_t1", strobe, 0);
    tick(); chk("rs_t2", strobe, 1);

    // Start and enable together: tick not counted.
    enable = 1'b1;
    go(8'd1, 1'b0);
    enable = 1'b0;
    chk("se_ready", tick_ready, 1);
    step();
    step();
    chk("se_still_run", tick_ready, 1);
    step();
    chk("se_no_strobe", strobe, 0);
    tick(); chk("se_t1", strobe, 1);
    chk("se_done", done, 1);

    // Reset one cycle after the period-th tick is accepted.
    go(8'd2, 1'b1);
    tick();
    enable = 1'b1;
    step();
    enable = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", tick_ready, 0);
    step();
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      step();
      if (strobe) seen++;
    end
    chk("rst_mid_no_strobe", seen, 0);
    chk("rst_mid_idle", busy, 0);
`ifdef PIPELINED_TIMER_EVENT_COUNT_EN
    chk("rst_mid_event_count", event_count, 0);
`endif

    // Wide instance: period 130 crosses the chunk 0 -> 1 carry at tick 128.
    start2 = 1'b1; period2 = 32'd130; mode2 = 1'b0;
    step();
    start2 = 1'b0;
    chk("w_busy", busy2, 1);
    for (int i = 0; i < 130; i++) begin
      tick2();
      chk("w_strobe", strobe2, (i == 129) ? 32'd1 : 32'd0);
    end
    chk("w_no_early_strobe", early2, 0);
    chk("w_done", done2, 1);
    chk("w_idle", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
